bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arb_pkg.sv | 8 +
 rtl/bram_arb_rr.sv | 25 ++
 rtl/bram_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared FSM state type, read-latency limits and counter width
// for the BRAM arbiter.
package bram_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/bram_arb_rr.sv
// bram_arb_rr: round-robin pick, searching from (i_last + 1) mod NUM_CH.
module bram_arb_rr
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx
);
    logic [IDX_W-1:0] w_j;

    // Walk farthest-first so the nearest requester after i_last wins last.
    always_comb begin
        w_j   = '0;
        o_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_j = IDX_W'((int'(i_last) + k) % NUM_CH);
            if (i_req[w_j]) o_idx = w_j;
        end
        o_gnt = |i_req ? NUM_CH'(1) << o_idx : '0;
    end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin multi-channel BRAM port arbiter with burst preemption
// and read-data return. Define BRAM_ARB_PERF_EN for per-channel access counters.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                          clk_BRAM,
    input  logic                          rstn_BRAM,
    input  logic [NUM_CH-1:0]             ch_req,
    output logic [NUM_CH-1:0]             ch_gnt,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH*(DATA_W/8)-1:0]  ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]      ch_dout,
    output logic [NUM_CH*DATA_W-1:0]      ch_din,
    output logic [NUM_CH-1:0]             ch_rvalid,
    output logic [ADDR_W-1:0]             addr_BRAM,
    output logic [DATA_W-1:0]             dout_BRAM,
    output logic                          en_BRAM,
    output logic [DATA_W/8-1:0]           we_BRAM,
    input  logic [DATA_W-1:0]             din_BRAM,
    output logic [NUM_CH*CNT_W-1:0]       acc_cnt
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int BE_W  = DATA_W / 8;
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_owner, w_owner_nxt, w_rr_idx;
    logic [NUM_CH-1:0]   w_rr_oh, w_own_oh;
    logic [BC_W-1:0]     r_burst, w_burst_nxt, w_burst_inc;
    logic                r_drain, w_drain_nxt;
    logic                w_own, w_acc, w_rd, w_others;
    logic [BE_W-1:0]     w_we;
    logic [RD_LAT-1:0]   r_rd_v;
    logic [IDX_W-1:0]    r_rd_idx [RD_LAT];

    bram_arb_rr #(.NUM_CH(NUM_CH)) u_rr (
        .i_req  (ch_req),
        .i_last (r_owner),
        .o_gnt  (w_rr_oh),
        .o_idx  (w_rr_idx)
    );

    // Grant is gated by the owner's live request so a dropped request is never granted.
    assign w_own_oh    = (r_state == OWN) ? NUM_CH'(1) << r_owner : '0;
    assign ch_gnt      = w_own_oh & ch_req;
    assign w_own       = |ch_gnt;
    assign w_acc       = w_own & ch_en[r_owner];
    assign w_we        = w_acc ? ch_we[r_owner*BE_W +: BE_W] : '0;
    assign w_rd        = w_acc & ~|w_we;
    assign w_others    = |(ch_req & ~(NUM_CH'(1) << r_owner));
    assign w_burst_inc = (r_burst == BC_W'(MAX_BURST)) ? r_burst : r_burst + BC_W'(w_acc);

    assign en_BRAM   = w_acc;
    assign we_BRAM   = w_we;
    assign addr_BRAM = w_own ? ch_addr[r_owner*ADDR_W +: ADDR_W] : '0;
    assign dout_BRAM = w_own ? ch_dout[r_owner*DATA_W +: DATA_W] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_burst_nxt = r_burst;
        w_drain_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_rr_oh) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = w_rr_idx;
                    w_burst_nxt = '0;
                end
            end
            OWN: begin
                w_burst_nxt = w_burst_inc;
                // With nothing issued there is nothing to drain: re-arbitrate at once.
                if (!w_own)
                    w_state_nxt = (r_burst == '0) ? IDLE : DRAIN;
                else if (w_burst_inc == BC_W'(MAX_BURST) && w_others)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_burst_nxt = '0;
                w_drain_nxt = 1'b1;
                if (r_drain == 1'(RD_LAT - 1)) begin
                    w_drain_nxt = 1'b0;
                    w_state_nxt = |w_rr_oh ? OWN : IDLE;
                    w_owner_nxt = |w_rr_oh ? w_rr_idx : r_owner;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_BRAM or negedge rstn_BRAM) begin
        if (!rstn_BRAM) begin
            r_state <= IDLE;
            r_owner <= IDX_W'(NUM_CH - 1);
            r_burst <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_burst <= w_burst_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    always_ff @(posedge clk_BRAM or negedge rstn_BRAM) begin
        if (!rstn_BRAM) begin
            r_rd_v <= '0;
            for (int k = 0; k < RD_LAT; k++) r_rd_idx[k] <= '0;
        end else begin
            r_rd_v[0]   <= w_rd;
            r_rd_idx[0] <= r_owner;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_v[k]   <= r_rd_v[k-1];
                r_rd_idx[k] <= r_rd_idx[k-1];
            end
        end
    end

    assign ch_rvalid = r_rd_v[RD_LAT-1] ? NUM_CH'(1) << r_rd_idx[RD_LAT-1] : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_din
        assign ch_din[i*DATA_W +: DATA_W] = ch_rvalid[i] ? din_BRAM : '0;
    end

`ifdef BRAM_ARB_PERF_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk_BRAM or negedge rstn_BRAM) begin
            if (!rstn_BRAM)
                r_cnt <= '0;
            else if (w_acc && r_owner == IDX_W'(i) && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
        assign acc_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`else
    assign acc_cnt = '0;
`endif
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench with a read-return scoreboard and a
// latency-2 BRAM model; NUM_CH=4, RD_LAT=2, MAX_BURST=4.
module tb_bram_arbiter;
    localparam int NCH = 4;
    localparam int LAT = 2;
    localparam int MB  = 4;
`ifdef BRAM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int          ch;
        logic [31:0] data;
        int          cyc;
    } rd_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NCH-1:0]  ch_req = '0, ch_gnt, ch_en = '0, ch_rvalid;
    logic [NCH*4-1:0]  ch_we = '0;
    logic [NCH*32-1:0] ch_addr = '0, ch_dout = '0, ch_din;
    logic [31:0]     addr_BRAM, dout_BRAM, din_BRAM = '0, q1 = '0;
    logic            en_BRAM;
    logic [3:0]      we_BRAM;
    logic [NCH*16-1:0] acc_cnt;

    int n_tests = 0, n_fail = 0, cyc = 0, wr_cnt = 0, rv_cnt = 0;
    int exp_acc [NCH];
    rd_t sb [$];
    rd_t ev;
    logic [NCH*32-1:0] exp_din;
    logic [31:0] mem [256];

    bram_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk_BRAM(clk), .rstn_BRAM(rstn), .ch_req(ch_req), .ch_gnt(ch_gnt),
        .ch_en(ch_en), .ch_we(ch_we), .ch_addr(ch_addr), .ch_dout(ch_dout),
        .ch_din(ch_din), .ch_rvalid(ch_rvalid), .addr_BRAM(addr_BRAM),
        .dout_BRAM(dout_BRAM), .en_BRAM(en_BRAM), .we_BRAM(we_BRAM),
        .din_BRAM(din_BRAM), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (en_BRAM) begin
            for (int b = 0; b < 4; b++)
                if (we_BRAM[b]) mem[addr_BRAM[7:0]][b*8 +: 8] <= dout_BRAM[b*8 +: 8];
            q1 <= mem[addr_BRAM[7:0]];
        end
        din_BRAM <= q1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic [NCH-1:0] g, output int n);
        n = 0;
        while (ch_gnt !== g && n < 20) begin
            tick();
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (en_BRAM && |we_BRAM) wr_cnt++;
        if (ch_gnt == '0)
            check("bram_idle_zero", {en_BRAM, we_BRAM, addr_BRAM, dout_BRAM}, '0);
        if (|ch_rvalid) begin
            rv_cnt++;
            if (sb.size() == 0) check("rvalid_unexpected", ch_rvalid, '0);
            else begin
                ev = sb.pop_front();
                exp_din = '0;
                exp_din[ev.ch*32 +: 32] = ev.data;
                check("rvalid_ch", ch_rvalid, NCH'(1) << ev.ch);
                check("rdata", ch_din, exp_din);
                check("rlat", cyc, ev.cyc);
            end
        end
    end

    initial begin
        int n, z, w0, nrd, rv0;
        logic any_en;
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int c = 0; c < NCH; c++) exp_acc[c] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", ch_gnt, '0);
        check("rst_rvalid_din", {ch_rvalid, ch_din}, '0);
        check("rst_bram", {en_BRAM, we_BRAM, addr_BRAM, dout_BRAM}, '0);
        check("rst_acc", acc_cnt, '0);

        rstn = 1'b1;
        ch_req = 4'b0011;
        tick();
        check("first_gnt_ch0", ch_gnt, 4'b0001);
        ch_en = 4'b0001; ch_we[3:0] = 4'hF;
        ch_addr[31:0] = 32'h10; ch_dout[31:0] = 32'hDEADBEEF;
        #1;
        check("owner_drive", {en_BRAM, we_BRAM, addr_BRAM, dout_BRAM}, {1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
        exp_acc[0]++;
        tick();
        ch_en = '0; ch_we = '0; ch_req = 4'b0010;
        #1;
        check("drop_gnt_low", ch_gnt, '0);
        wait_gnt(4'b0010, n);
        check("ch1_gnt_after_drain", ch_gnt, 4'b0010);
        check("drain_cycles", n, 1 + LAT);
        ch_req = '0;
        tick();
        tick();

        ch_req = 4'b0100;
        wait_gnt(4'b0100, n);
        check("ch2_gnt", {ch_gnt, 8'(n)}, {4'b0100, 8'd1});
        ch_en = 4'b0100; ch_we = '0; ch_addr[2*32 +: 32] = 32'h10;
        sb.push_back('{2, 32'hDEADBEEF, cyc + LAT});
        exp_acc[2]++;
        tick();
        ch_en = '0; ch_req = '0;
        repeat (4) tick();

        ch_req = 4'b0001;
        wait_gnt(4'b0001, n);
        check("ch0_gnt", ch_gnt, 4'b0001);
        ch_req = 4'b0011; ch_en = 4'b0001; ch_we[3:0] = 4'hF;
        ch_addr[31:0] = 32'h20; ch_dout[31:0] = 32'h11111111;
        w0 = wr_cnt; z = 0; n = 0;
        while (ch_gnt !== 4'b0010 && n < 20) begin
            if (ch_gnt == '0) z++;
            tick();
            n++;
        end
        check("preempt_gnt_ch1", ch_gnt, 4'b0010);
        check("burst_writes", wr_cnt - w0, MB);
        check("preempt_gap", z, LAT);
        exp_acc[0] += MB;
        ch_en = 4'b0010; ch_we = '0; ch_addr[32 +: 32] = 32'h20;
        nrd = 0;
        for (int k = 0; k < 6; k++) begin
            if (ch_gnt[1]) begin
                sb.push_back('{1, 32'h11111111, cyc + LAT});
                nrd++;
            end
            tick();
        end
        check("ch1_read_burst", nrd, MB);
        exp_acc[1] += MB;

        ch_req = 4'b0001; ch_en = 4'b0010;
        wait_gnt(4'b0001, n);
        check("ch0_regrant", ch_gnt, 4'b0001);
        any_en = 1'b0;
        repeat (3) begin
            any_en |= en_BRAM;
            tick();
        end
        check("ungranted_en_dropped", any_en, 1'b0);
        check("acc1_unchanged", acc_cnt[16 +: 16], PERF ? 16'(exp_acc[1]) : 16'h0);
        check("acc0_count", acc_cnt[15:0], PERF ? 16'(exp_acc[0]) : 16'h0);

        ch_en = 4'b0001; ch_we = '0; ch_addr[31:0] = 32'h10;
        tick();
        rv0 = rv_cnt;
        rstn = 1'b0;
        #1;
        check("async_rst_bram", {en_BRAM, we_BRAM, addr_BRAM, dout_BRAM}, '0);
        check("async_rst_gnt_rv", {ch_gnt, ch_rvalid, ch_din}, '0);
        check("async_rst_acc", acc_cnt, '0);
        ch_en = '0; ch_req = '0;
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        check("no_rvalid_after_rst", rv_cnt, rv0);

`ifdef BRAM_ARB_PERF_EN
        ch_req = 4'b0001;
        wait_gnt(4'b0001, n);
        ch_en = 4'b0001; ch_we[3:0] = 4'hF; ch_addr[31:0] = 32'h0;
        repeat (70000) tick();
        check("acc0_saturate", acc_cnt[15:0], 16'hFFFF);
        ch_en = '0; ch_req = '0;
        repeat (4) tick();
`else
        ch_req = 4'b0001;
        wait_gnt(4'b0001, n);
        ch_en = 4'b0001; ch_we[3:0] = 4'hF;
        repeat (10) tick();
        check("acc_const_zero", acc_cnt, '0);
        ch_en = '0; ch_req = '0;
        repeat (4) tick();
`endif
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
